// File: rtl/button_debounce_mb.sv
// button_debounce_mb
//   Multi-channel push-button conditioner.
//   Each raw button (active low, asynchronous to clk) is synchronized through
//   two flops and inverted to active high. Each channel then runs a debounce
//   counter. The debounced level changes only after DEBOUNCE_CYCLES
//   consecutive synchronized samples disagree with the current level. Press
//   and release events are reported as single-cycle pulses.
//
//   Optional feature macro: BUTTON_DEBOUNCE_MB_LONG_PRESS_EN
//     defined   -> per-channel hold counter; btn_long pulses once when the
//                  press has been held for LONG_CYCLES cycles.
//     undefined -> btn_long is tied to 0 and no hold counters exist.
//
// Ports
//   clk          in   clock; all state changes on its rising edge
//   rst          in   asynchronous, active-high reset
//   button_mb    in   [N_BTN] raw buttons, active low
//   btn_level    out  [N_BTN] debounced state, 1 = pressed
//   btn_press    out  [N_BTN] one-cycle pulse on a debounced press
//   btn_release  out  [N_BTN] one-cycle pulse on a debounced release
//   btn_long     out  [N_BTN] one-cycle pulse on a long press
//   any_pressed  out  OR of btn_level
module button_debounce_mb #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] button_mb,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             any_pressed
);

  localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value reached after DEBOUNCE_CYCLES-1 differing edges; the next
  // differing edge is the one that commits the new level.
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Reject illegal parameter sets at elaboration.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_debounce_mb: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("button_debounce_mb: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [CW-1:0]    cnt      [N_BTN];
  logic [CW-1:0]    cnt_next [N_BTN];
  logic [N_BTN-1:0] level_next;

  // Two-flop synchronizer; inversion happens at the first flop so the
  // released state (raw high) resets cleanly to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~button_mb;
      sync2 <= sync1;
    end
  end

  // Debounce decision: count consecutive disagreeing samples and commit the
  // new level on the DEBOUNCE_CYCLES-th one. Any agreeing sample restarts.
  always_comb begin
    level_next = btn_level;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != btn_level[i]) begin
        if (cnt[i] == C_LAST) begin
          level_next[i] = sync2[i];
          cnt_next[i]   = '0;
        end else begin
          cnt_next[i]   = cnt[i] + CW'(1);
        end
      end else begin
        cnt_next[i] = '0;
      end
    end
  end

  // Debounce state and edge pulses. btn_level is the stable-state register
  // itself, so edge pulses are computed from its next value to land in the
  // first cycle of the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      btn_level   <= level_next;
      btn_press   <= level_next & ~btn_level;
      btn_release <= ~level_next & btn_level;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

`ifdef BUTTON_DEBOUNCE_MB_LONG_PRESS_EN
  localparam int            HW     = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] H_FIRE = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold [N_BTN];

  // Hold counters: the press cycle is hold cycle 1 (the counter steps at the
  // end of it). btn_long is raised on the edge where the counter reaches
  // LONG_CYCLES; saturation stops it from firing again until a release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_long <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (btn_level[i]) begin
          if (hold[i] != H_MAX) begin
            hold[i] <= hold[i] + HW'(1);
          end else begin
            hold[i] <= hold[i];
          end
        end else begin
          hold[i] <= '0;
        end
        btn_long[i] <= btn_level[i] && (hold[i] == H_FIRE);
      end
    end
  end
`else
  assign btn_long = '0;
`endif

  assign any_pressed = |btn_level;

endmodule

// File: tb/tb_button_debounce_mb.sv
// tb_button_debounce_mb
//   Randomized and directed bench for button_debounce_mb with
//   DEBOUNCE_CYCLES=4, LONG_CYCLES=10. The reference model is kept at the
//   level of the requirements: a 2-sample delay line, a window of the last
//   DEBOUNCE_CYCLES synchronized samples (level flips when all of them
//   disagree with it), and a count of cycles held since the press.
module tb_button_debounce_mb;
  localparam int NB = 4;
  localparam int DC = 4;
  localparam int LC = 10;
`ifdef BUTTON_DEBOUNCE_MB_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [NB-1:0] button_mb;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_long;
  logic          any_pressed;

  int total = 0;
  int bad   = 0;

  button_debounce_mb #(
    .N_BTN(NB),
    .DEBOUNCE_CYCLES(DC),
    .LONG_CYCLES(LC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button_mb(button_mb),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_long(btn_long),
    .any_pressed(any_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [NB-1:0] m_pipe0, m_pipe1;
  logic [NB-1:0] m_hist [DC];
  logic [NB-1:0] m_level, m_press, m_release, m_long;
  int            m_hold [NB];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_pipe0 = '0; m_pipe1 = '0;
    for (int j = 0; j < DC; j++) m_hist[j] = '0;
    m_level = '0; m_press = '0; m_release = '0; m_long = '0;
    for (int i = 0; i < NB; i++) m_hold[i] = 0;
  endtask

  // One clock edge of the requirement-level model.
  task automatic model_step();
    logic [NB-1:0] seen, nl;
    bit flip;
    seen    = m_pipe1;
    m_pipe1 = m_pipe0;
    m_pipe0 = ~button_mb;
    for (int j = DC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = seen;
    nl = m_level;
    for (int i = 0; i < NB; i++) begin
      flip = 1'b1;
      for (int j = 0; j < DC; j++) if (m_hist[j][i] == m_level[i]) flip = 1'b0;
      if (flip) nl[i] = ~m_level[i];
      if (m_level[i]) m_hold[i]++;
      else            m_hold[i] = 0;
      m_long[i] = LONG_EN && m_level[i] && (m_hold[i] == LC);
    end
    m_press   = nl & ~m_level;
    m_release = ~nl & m_level;
    m_level   = nl;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".level"},   32'(btn_level),   32'(m_level));
    check_eq({tag, ".press"},   32'(btn_press),   32'(m_press));
    check_eq({tag, ".release"}, 32'(btn_release), 32'(m_release));
    check_eq({tag, ".long"},    32'(btn_long),    32'(m_long));
    check_eq({tag, ".any"},     32'(any_pressed), 32'(|m_level));
  endtask

  // Called at a falling edge: drive, step through one rising edge, check.
  task automatic cycle(input logic [NB-1:0] b, input string tag);
    button_mb = b;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  // Called at a falling edge: reset pulse of one cycle, checked immediately.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_clear();
    compare_all({tag, ".rst_now"});
    @(negedge clk);
    compare_all({tag, ".rst_hold"});
    rst = 1'b0;
  endtask

  // Drive b until btn_press[ch] is seen; n = cycles taken (bounded).
  task automatic wait_press(input int ch, input logic [NB-1:0] b, input string tag, output int n);
    n = 0;
    do begin
      cycle(b, tag);
      n++;
    end while (!btn_press[ch] && n < 30);
  endtask

  initial begin
    logic [NB-1:0] b;
    int n, np, nr, nl, p0, p3, pc, lcyc;
    int run [NB];

    rst = 1'b1;
    button_mb = '1;
    model_clear();
    @(negedge clk);
    compare_all("por");
    rst = 1'b0;
    repeat (3) cycle(4'b1111, "idle");

    // clean press on channel 0
    wait_press(0, 4'b1110, "clean", n);
    check_eq("clean_latency", 32'(n), 32'd6);
    repeat (3) cycle(4'b1110, "clean_hold");
    repeat (8) cycle(4'b1111, "clean_rel");

    // bounce on channel 1: low 3, high 1, then steady low
    np = 0; nr = 0;
    repeat (3) cycle(4'b1101, "bounce_lo");
    cycle(4'b1111, "bounce_hi");
    n = 0; lcyc = -1;
    repeat (12) begin
      cycle(4'b1101, "bounce_steady");
      n++;
      if (btn_press[1]) begin np++; lcyc = n; end
      if (btn_release[1]) nr++;
    end
    check_eq("bounce_press_cnt", 32'(np), 32'd1);
    check_eq("bounce_latency", 32'(lcyc), 32'd6);
    check_eq("bounce_release_cnt", 32'(nr), 32'd0);
    repeat (8) cycle(4'b1111, "bounce_rel");

    // simultaneous press/release on channels 0 and 3
    p0 = -1; p3 = -1;
    for (int c = 0; c < 10; c++) begin
      cycle(4'b0110, "dual_press");
      if (btn_press[0]) p0 = c;
      if (btn_press[3]) p3 = c;
    end
    check_eq("dual_press_same", 32'(p0), 32'(p3));
    check_eq("dual_any", 32'(any_pressed), 32'd1);
    p0 = -1; p3 = -1;
    for (int c = 0; c < 10; c++) begin
      cycle(4'b1111, "dual_rel");
      if (btn_release[0]) p0 = c;
      if (btn_release[3]) p3 = c;
    end
    check_eq("dual_rel_same", 32'(p0), 32'(p3));
    check_eq("dual_any_rel", 32'(any_pressed), 32'd0);

    // long press on channel 2
    nl = 0; pc = -1; lcyc = -1;
    for (int c = 0; c < 20; c++) begin
      cycle(4'b1011, "long_hold");
      if (btn_press[2]) pc = c;
      if (btn_long[2]) begin nl++; lcyc = c; end
    end
    check_eq("long_cnt", 32'(nl), LONG_EN ? 32'd1 : 32'd0);
`ifdef BUTTON_DEBOUNCE_MB_LONG_PRESS_EN
    check_eq("long_delay", 32'(lcyc - pc), 32'd10);
`endif
    repeat (8) cycle(4'b1111, "long_rel");

    // reset mid-count, button still held afterwards
    repeat (4) cycle(4'b1110, "rst_mid");
    do_reset("rst_mid");
    wait_press(0, 4'b1110, "rst_mid_after", n);
    check_eq("rst_mid_latency", 32'(n), 32'd6);
    // reset during a held press
    repeat (3) cycle(4'b1110, "rst_held");
    do_reset("rst_held");
    wait_press(0, 4'b1110, "rst_held_after", n);
    check_eq("rst_held_latency", 32'(n), 32'd6);
    repeat (8) cycle(4'b1111, "rst_rel");

    // randomized bouncy stimulus with occasional resets
    b = '1;
    for (int i = 0; i < NB; i++) run[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (run[i] == 0) begin
          b[i] = ~b[i];
          run[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 25));
        end else begin
          run[i]--;
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        button_mb = b;
        do_reset("rand");
      end else begin
        cycle(b, "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
